// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, oversampling encodings and helpers
package uart_pkg;

   localparam int DIV_W_DEF  = 16;
   localparam int FRAC_W_DEF = 4;
   localparam int OSR_16     = 16;
   localparam int OSR_8      = 8;

   typedef enum logic {
      OSR_SEL_16X = 1'b0,
      OSR_SEL_8X  = 1'b1
   } osr_sel_e;

   // Highest oversample index for the selected ratio.
   function automatic logic [3:0] osr_last(input logic sel);
      return (sel == OSR_SEL_8X) ? 4'(OSR_8 - 1) : 4'(OSR_16 - 1);
   endfunction

endpackage

// File: rtl/uart_os_phase_cnt.sv
// rtl/uart_os_phase_cnt.sv - mod-8/16 oversample phase counter with wrap pulse
module uart_os_phase_cnt
   import uart_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       inc_i,
   input  logic       clr_i,
   input  logic       osr_sel_i,
   output logic [3:0] phase_o,
   output logic       wrap_o
);

   logic [3:0] phase_q, phase_d;
   logic       wrap;

   // ">=" rather than "==" so a phase beyond a newly shortened ratio wraps at once.
   always_comb begin
      phase_d = phase_q;
      wrap    = 1'b0;
      if (clr_i) begin
         phase_d = '0;
      end else if (inc_i) begin
         if (phase_q >= osr_last(osr_sel_i)) begin
            phase_d = '0;
            wrap    = 1'b1;
         end else begin
            phase_d = phase_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_o = phase_q;
   assign wrap_o  = wrap;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional-divisor UART baud generator with oversample and bit strobes
module uart_baud_gen_frac
   import uart_pkg::*;
#(
   parameter int DIV_W  = DIV_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
)
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic [DIV_W-1:0]  baud_div_i,
   input  logic [FRAC_W-1:0] baud_frac_i,
   input  logic              osr_sel_i,
   input  logic              resync_i,
   output logic              tick_os_o,
   output logic              tick_1x_o,
   output logic [3:0]        os_phase_o,
   output logic              cfg_err_o
);

   logic [DIV_W-1:0]  div_s_q, div_s_d;
   logic [FRAC_W-1:0] frac_s_q, frac_s_d;
   logic              osr_s_q, osr_s_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              carry_q, carry_d;
   logic              tick_os_q, tick_os_d;
   logic              tick_1x_q, tick_1x_d;
   logic              cfg_err_q, cfg_err_d;

   logic              div_bad;
   logic              run;
   logic              term;
   logic              load;
   logic [FRAC_W:0]   acc_sum;
   logic              phase_wrap;

   assign div_bad = (div_s_q < DIV_W'(2));
   assign run     = en_i && !div_bad && !resync_i;
   // Extended period compares against div_s itself, so div_s+1 never has to be formed.
   assign term    = run && (carry_q ? (cnt_q == div_s_q) : (cnt_q == div_s_q - DIV_W'(1)));
   assign load    = term || resync_i || !en_i || div_bad;
   assign acc_sum = {1'b0, acc_q} + {1'b0, frac_s_q};

   always_comb begin
      div_s_d   = div_s_q;
      frac_s_d  = frac_s_q;
      osr_s_d   = osr_s_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      tick_os_d = term;
      tick_1x_d = term && phase_wrap;
      cfg_err_d = div_bad;

      if (load) begin
         div_s_d  = baud_div_i;
         frac_s_d = baud_frac_i;
         osr_s_d  = osr_sel_i;
      end

      if (resync_i || div_bad) begin
         cnt_d   = '0;
         acc_d   = '0;
         carry_d = 1'b0;
      end else if (term) begin
         cnt_d   = '0;
         acc_d   = acc_sum[FRAC_W-1:0];
         carry_d = acc_sum[FRAC_W];
      end else if (en_i) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         div_s_q   <= baud_div_i;
         frac_s_q  <= baud_frac_i;
         osr_s_q   <= osr_sel_i;
         cnt_q     <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         tick_os_q <= 1'b0;
         tick_1x_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         div_s_q   <= div_s_d;
         frac_s_q  <= frac_s_d;
         osr_s_q   <= osr_s_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         tick_os_q <= tick_os_d;
         tick_1x_q <= tick_1x_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // The ratio being shadowed this cycle drives the wrap, so a switch lands on the ending tick.
   uart_os_phase_cnt u_phase (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .inc_i     (term),
      .clr_i     (resync_i || div_bad),
      .osr_sel_i (osr_s_d),
      .phase_o   (os_phase_o),
      .wrap_o    (phase_wrap)
   );

   assign tick_os_o = tick_os_q;
   assign tick_1x_o = tick_1x_q;
   assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - scoreboard bench for uart_baud_gen_frac
module tb_uart_baud_gen_frac;

   typedef struct {
      int unsigned cyc;
      int unsigned ph;
      int unsigned one_x;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] baud_div;
   logic [3:0]  baud_frac;
   logic        osr_sel;
   logic        resync;
   logic        tick_os;
   logic        tick_1x;
   logic [3:0]  os_phase;
   logic        cfg_err;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        exp_q[$];
   int unsigned tick_log[$];
   int unsigned t_last;
   int          ph_m;
   int          osr_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_baud_gen_frac dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .baud_div_i  (baud_div),
      .baud_frac_i (baud_frac),
      .osr_sel_i   (osr_sel),
      .resync_i    (resync),
      .tick_os_o   (tick_os),
      .tick_1x_o   (tick_1x),
      .os_phase_o  (os_phase),
      .cfg_err_o   (cfg_err)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (tick_1x && !tick_os) begin
            total++;
            bad++;
            $display("FAIL tick_1x_alone: actual tick_1x=1 tick_os=0 required coincident (cyc=%0d)", cyc);
         end
         if (tick_os) begin
            tick_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tick: actual tick at cyc=%0d phase=%0d required none", cyc, os_phase);
            end else begin
               e = exp_q.pop_front();
               chk("tick_cyc", cyc, e.cyc);
               chk("tick_phase", int'(os_phase), e.ph);
               chk("tick_1x", int'(tick_1x), e.one_x);
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_tick(input int unsigned p);
      exp_t e;
      t_last  = t_last + p;
      ph_m    = (ph_m + 1 >= osr_m) ? 0 : ph_m + 1;
      e.cyc   = t_last;
      e.ph    = ph_m;
      e.one_x = (ph_m == 0) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic push_run(input int n, input int unsigned p);
      for (int i = 0; i < n; i++) push_tick(p);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         step(1);
         k++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: actual pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input int unsigned div, input int unsigned frac, input logic osr);
      baud_div  = 16'(div);
      baud_frac = 4'(frac);
      osr_sel   = osr;
      en        = 1'b1;
      resync    = 1'b0;
      rst_n     = 1'b0;
      step(1);
      chk("rst_tick_os", int'(tick_os), 0);
      chk("rst_tick_1x", int'(tick_1x), 0);
      chk("rst_os_phase", int'(os_phase), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      rst_n  = 1'b1;
      t_last = cyc;
      ph_m   = 0;
      osr_m  = osr ? 8 : 16;
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      baud_div  = 16'd5;
      baud_frac = 4'd0;
      osr_sel   = 1'b0;
      resync    = 1'b0;
      fork
         mon_loop();
      join_none
      step(2);

      // integer divide, 16x
      do_reset(5, 0, 1'b0);
      push_run(32, 5);
      drain(400);
      chk("cfg_err_normal", int'(cfg_err), 0);

      // half-clock fraction: 5,5,6,5,6...
      do_reset(5, 8, 1'b0);
      tick_log.delete();
      push_tick(5);
      push_tick(5);
      for (int i = 0; i < 8; i++) begin
         push_tick(6);
         push_tick(5);
      end
      drain(300);
      chk("frac_tick_count", tick_log.size(), 18);
      if (tick_log.size() == 18) chk("frac_span16", tick_log[17] - tick_log[1], 88);

      // 8x oversampling
      do_reset(3, 0, 1'b1);
      push_run(16, 3);
      drain(200);

      // 16x -> 8x switch at phase 12
      do_reset(4, 0, 1'b0);
      push_run(12, 4);
      drain(200);
      chk("pre_switch_phase", int'(os_phase), 12);
      osr_sel = 1'b1;
      osr_m   = 8;
      push_run(9, 4);
      drain(200);

      // resync at cnt=3
      do_reset(10, 8, 1'b0);
      push_tick(10);
      drain(100);
      step(2);
      resync = 1'b1;
      step(1);
      resync = 1'b0;
      chk("resync_phase", int'(os_phase), 0);
      t_last = cyc;
      ph_m   = 0;
      push_tick(10);
      push_tick(10);
      push_tick(11);
      drain(100);

      // enable gap of 7, then div change while disabled
      do_reset(6, 0, 1'b0);
      push_tick(6);
      drain(100);
      step(1);
      en = 1'b0;
      push_tick(13);
      step(7);
      en = 1'b1;
      drain(100);
      en       = 1'b0;
      baud_div = 16'd4;
      push_tick(7);
      push_run(2, 4);
      step(3);
      en = 1'b1;
      drain(100);

      // illegal divisor, recovery, mid-period reset
      do_reset(1, 0, 1'b0);
      step(2);
      chk("cfg_err_set", int'(cfg_err), 1);
      step(20);
      en       = 1'b0;
      baud_div = 16'd5;
      step(1);
      chk("cfg_err_hold", int'(cfg_err), 1);
      step(1);
      chk("cfg_err_clear", int'(cfg_err), 0);
      en     = 1'b1;
      t_last = cyc;
      ph_m   = 0;
      push_run(2, 5);
      drain(100);
      step(1);
      chk("pre_reset_phase", int'(os_phase), 2);
      do_reset(5, 0, 1'b0);
      push_run(4, 5);
      drain(100);

      en = 1'b0;
      step(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
